// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Function : Round-robin arbiter sharing one memory port between two
//            requesters, one transaction in flight at a time.
//            Optional BUSY timeout abort enabled by `define MEM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          gnt_id,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_last;
  logic          w_any_req;
  logic          w_winner;
  logic          w_timeout;
  logic          w_finish;
  logic [DW-1:0] w_cap_data;

  assign w_any_req = p0_req | p1_req;
  // Both requesting: the port that did not win last time gets the grant.
  assign w_winner  = (p0_req && p1_req) ? ~r_last : p1_req;
  assign w_finish  = (r_state == BUSY) && (mem_ready || w_timeout);
  assign w_cap_data = (mem_we || w_timeout) ? '0 : mem_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // mem_ready in the same cycle as the limit is a normal completion.
  assign w_timeout = (r_state == BUSY) && !mem_ready && (r_cnt == C_TIMEOUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != BUSY)
        r_cnt <= '0;
      else if (!mem_ready)
        r_cnt <= r_cnt + 1'b1;
      if (w_finish)
        r_err <= w_timeout;
      else if (r_state == IDLE)
        r_err <= 1'b0;
    end
  end

  assign err = (r_state == RESP) && r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = BUSY;
      BUSY:    if (mem_ready || w_timeout) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Winner's request is latched so the memory side never re-samples the ports.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last    <= 1'b1;
      gnt_id    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      p0_rdata  <= '0;
      p1_rdata  <= '0;
    end else begin
      if ((r_state == IDLE) && w_any_req) begin
        gnt_id    <= w_winner;
        r_last    <= w_winner;
        mem_we    <= w_winner ? p1_we    : p0_we;
        mem_addr  <= w_winner ? p1_addr  : p0_addr;
        mem_wdata <= w_winner ? p1_wdata : p0_wdata;
      end
      if (w_finish) begin
        if (gnt_id)
          p1_rdata <= w_cap_data;
        else
          p0_rdata <= w_cap_data;
      end
    end
  end

  assign mem_req = (r_state == BUSY);
  assign p0_done = (r_state == RESP) && !gnt_id;
  assign p1_done = (r_state == RESP) &&  gnt_id;

endmodule
`default_nettype wire
